// File: rtl/fcmp_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fcmp_arbiter_if
//  Description : Request/result bundle between the requesters and the shared
//                single-precision compare unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface fcmp_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    in_valid;
  logic [NREQ-1:0]    in_ready;
  logic [NREQ*32-1:0] in_srca;
  logic [NREQ*32-1:0] in_srcb;
  logic [NREQ*2-1:0]  in_op;
  logic               out_valid;
  logic [IDW-1:0]     out_id;
  logic               out_result;
  logic               out_ready;

  // Requester / consumer side
  modport master (
    output in_valid, in_srca, in_srcb, in_op, out_ready,
    input  in_ready, out_valid, out_id, out_result
  );

  // Compare unit side
  modport slave (
    input  in_valid, in_srca, in_srcb, in_op, out_ready,
    output in_ready, out_valid, out_id, out_result
  );
endinterface
`default_nettype wire

// File: rtl/fcmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fcmp_arbiter
//  Description : Round-robin arbiter sharing one flush-to-zero FP32 compare
//                (LT / EQ / LE) between NREQ requesters, with a one-deep
//                registered result stage tagged by requester index.
//  Revision    : 1.0  initial release
// ============================================================================
module fcmp_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  wire           clk,
  input  wire           rst,
  fcmp_arbiter_if.slave bus
);

  localparam logic [IDW:0]   NREQ_EXT = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  logic [IDW-1:0] rr_q, rr_d;
  logic           out_valid_q, out_valid_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic           out_result_q, out_result_d;

  logic            slot_free;
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    idx_ext;
  logic [NREQ-1:0] ready_vec;
  logic            transfer;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [1:0]      sel_op;
  logic            cmp_result;

  // Flush-to-zero sign/magnitude compare; reserved op 11 behaves as LT.
  function automatic logic fcmp(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    logic za, zb, lt, eq;
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    if (za && zb)           lt = 1'b0;
    else if (za)            lt = !b[31];
    else if (zb)            lt = a[31];
    else if (a[31] != b[31]) lt = a[31];
    else if (!a[31])        lt = (a[30:0] < b[30:0]);
    else                    lt = (a[30:0] > b[30:0]);
    if (za && zb)           eq = 1'b1;
    else if (za || zb)      eq = 1'b0;
    else                    eq = (a == b);
    case (op)
      2'b01:   fcmp = eq;
      2'b10:   fcmp = lt | eq;
      default: fcmp = lt;
    endcase
  endfunction

  // Pick the first valid requester starting at the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_ext     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_ext = {1'b0, rr_q} + (IDW+1)'(k);
      if (idx_ext >= NREQ_EXT) idx_ext = idx_ext - NREQ_EXT;
      if (!grant_found && bus.in_valid[idx_ext[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_ext[IDW-1:0];
      end
    end
  end

  // Grant only into a free slot, and never while reset is asserted.
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    ready_vec = '0;
    if (!rst && slot_free && grant_found) ready_vec[grant_idx] = 1'b1;
    transfer  = |ready_vec;
  end

  assign bus.in_ready = ready_vec;

  // Operand mux and compare for the granted requester.
  always_comb begin
    sel_a      = bus.in_srca[grant_idx*32 +: 32];
    sel_b      = bus.in_srcb[grant_idx*32 +: 32];
    sel_op     = bus.in_op[grant_idx*2 +: 2];
    cmp_result = fcmp(sel_op, sel_a, sel_b);
  end

  // Next-state: load on transfer, clear on drain, otherwise hold.
  always_comb begin
    rr_d         = rr_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    out_id_d     = out_id_q;
    out_result_d = out_result_q;
    if (transfer) begin
      rr_d         = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
      out_valid_d  = 1'b1;
      out_id_d     = grant_idx;
      out_result_d = cmp_result;
    end
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= '0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_result_q <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_result_q <= out_result_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = out_id_q;
  assign bus.out_result = out_result_q;

endmodule
`default_nettype wire

// File: tb/tb_fcmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fcmp_arbiter
//  Description : Self-checking bench for fcmp_arbiter: directed compare
//                vectors, arbitration/backpressure sequences and randomized
//                traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fcmp_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst;

  fcmp_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fcmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int   m_rr;
  bit   m_ov;
  int   m_id;
  bit   m_res;
  int   last_grant;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare from numeric value: zero-exponent operands are 0, otherwise
  // a signed integer built from sign and magnitude bits.
  function automatic bit ref_cmp(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    longint va, vb;
    if (a[30:23] == 8'd0) va = 0;
    else va = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    if (b[30:23] == 8'd0) vb = 0;
    else vb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    if (op == 2'b01) return va == vb;
    if (op == 2'b10) return va <= vb;
    return va < vb;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_ov = 0; m_id = 0; m_res = 0; last_grant = -1;
  endtask

  // One clock: check outputs against the model shortly after the inputs
  // settle, then advance the model at the rising edge.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    int g;
    bit r;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!rst && (!m_ov || bus.out_ready))
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && bus.in_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready",   bus.in_ready,   exp_rdy);
    chk("out_valid",  bus.out_valid,  m_ov);
    chk("out_id",     bus.out_id,     m_id);
    chk("out_result", bus.out_result, m_res);
    r = 1'b0;
    if (g >= 0) r = ref_cmp(bus.in_op[2*g +: 2], bus.in_srca[32*g +: 32], bus.in_srcb[32*g +: 32]);
    last_grant = g;
    @(posedge clk);
    if (rst) model_reset();
    else if (g >= 0) begin
      m_ov = 1; m_id = g; m_res = r; m_rr = (g + 1) % NREQ;
    end else if (bus.out_ready) m_ov = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.in_op[2*i +: 2]    = op;
    bus.in_srca[32*i +: 32] = a;
    bus.in_srcb[32*i +: 32] = b;
  endtask

  function automatic logic [31:0] rand_val(input logic [31:0] other);
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: begin v = $urandom; v[30:23] = 8'd0; end
      1: v = other;
      2: v = other + 32'($urandom_range(0, 2)) - 32'd1;
      3: v = other ^ 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'b00, 32'h3F80_0000, 32'h4000_0000, 1'b1};
    vecs[1]  = '{2'b00, 32'h4000_0000, 32'h3F80_0000, 1'b0};
    vecs[2]  = '{2'b00, 32'hBF80_0000, 32'h0000_0000, 1'b1};
    vecs[3]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 1'b1};
    vecs[4]  = '{2'b00, 32'h8000_0000, 32'h0000_0001, 1'b0};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'h0000_0001, 1'b1};
    vecs[6]  = '{2'b01, 32'h4000_0000, 32'h4000_0001, 1'b0};
    vecs[7]  = '{2'b00, 32'hC000_0000, 32'hBF80_0000, 1'b1};
    vecs[8]  = '{2'b11, 32'h3F80_0000, 32'h4000_0000, 1'b1};
    vecs[9]  = '{2'b10, 32'h4000_0000, 32'h4000_0000, 1'b1};
    vecs[10] = '{2'b00, 32'h0000_0000, 32'hBF80_0000, 1'b0};
    vecs[11] = '{2'b01, 32'hC000_0000, 32'h4000_0000, 1'b0};

    rst = 1'b1;
    bus.in_valid  = '0;
    bus.in_srca   = '0;
    bus.in_srcb   = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed compare vectors through requester 1
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 4'b0010;
      set_req(1, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      bus.in_valid = '0;
      #1;
      chk($sformatf("vec%0d_id", i),     bus.out_id,     32'd1);
      chk($sformatf("vec%0d_result", i), bus.out_result, vecs[i].exp);
      tick();
    end

    // Round-robin with all requesters valid and no backpressure
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_grant", bus.in_ready, 32'(4'b0001 << (i % 4)));
      if (i > 0) chk("rr_out_id", bus.out_id, 32'((i - 1) % 4));
      tick();
    end
    bus.in_valid = '0;
    tick();

    // Async reset while a result is stalled
    bus.in_valid = 4'b0100;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = '0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_in_ready",  bus.in_ready,  32'd0);
    model_reset();
    @(negedge clk);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1111;
    #1;
    chk("rst_rr_zero", bus.in_ready, 32'd1);
    tick();
    bus.in_valid = '0;
    tick();

    // Backpressure: stall with req0 and req2 pending, rr=1
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0001;
    set_req(0, 2'b00, 32'h3F80_0000, 32'h4000_0000);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", bus.in_ready,   32'd0);
      chk("stall_valid", bus.out_valid,  32'd1);
      chk("stall_id",    bus.out_id,     32'd0);
      chk("stall_res",   bus.out_result, 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_req2", bus.in_ready, 32'b0100);
    tick();
    bus.in_valid = 4'b0001;
    #1;
    chk("unstall_req0", bus.in_ready, 32'b0001);
    tick();
    bus.in_valid = '0;
    tick();

    // Requester 3 withdraws before being granted
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0001;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1100;
    tick();
    tick();
    bus.in_valid = 4'b0100;
    tick();
    bus.out_ready = 1'b1;
    #1;
    chk("drop_grant2", bus.in_ready, 32'b0100);
    tick();
    bus.in_valid = '0;
    #1;
    chk("drop_out_id", bus.out_id, 32'd2);
    tick();
    #1;
    chk("drop_no_id3", bus.out_valid, 32'd0);
    tick();

    // Randomized traffic; operands held until transfer, withdrawals allowed
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [NREQ-1:0] v;
      v = bus.in_valid;
      for (int i = 0; i < NREQ; i++) begin
        if (last_grant == i || !v[i]) begin
          v[i] = ($urandom_range(0, 99) < 55);
          if (v[i]) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[30:23] = 8'd0;
            set_req(i, 2'($urandom_range(0, 3)), a, rand_val(a));
          end
        end else if ($urandom_range(0, 99) < 5) v[i] = 1'b0;
      end
      bus.in_valid  = v;
      bus.out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
